mccpu_core: RTL and testbench

//  Multi-cycle MIPS32-subset CPU core; successor to the single-cycle core top.

---
 rtl/mccpu_pkg.sv | 62 ++++++
 rtl/mccpu_if.sv | 14 +
 rtl/mccpu_regfile.sv | 21 ++
 rtl/mccpu_core.sv | 181 ++++++++++++++++++
 tb/tb_mccpu_core.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mccpu_pkg.sv
// rtl/mccpu_pkg.sv - opcode/funct constants, ALU ops and FSM states for the multi-cycle core
package mccpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_LUI
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Shifts operate on b (rt) by shamt; lui places b's low half on top.
  function automatic logic [31:0] alu_calc(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'h0, $signed(a) < $signed(b)};
      ALU_SLL: r = b << sh;
      ALU_SRL: r = b >> sh;
      ALU_LUI: r = {b[15:0], 16'h0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mccpu_if.sv
// rtl/mccpu_if.sv - shared instruction/data memory port with req/ready handshake
interface mccpu_if #(parameter int ADDR_W = 32);
  logic              Mem_Req;
  logic              Mem_Wen;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_Wdata;
  logic [31:0]       Mem_Rdata;
  logic              Mem_Ready;

  modport master (output Mem_Req, Mem_Wen, Mem_Addr, Mem_Wdata,
                  input  Mem_Rdata, Mem_Ready);
  modport slave  (input  Mem_Req, Mem_Wen, Mem_Addr, Mem_Wdata,
                  output Mem_Rdata, Mem_Ready);
endinterface

// File: rtl/mccpu_regfile.sv
// rtl/mccpu_regfile.sv - 32x32 register file, two async reads, one sync write, r0 reads zero
module mccpu_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  // Contents survive reset; r0 is never written and always reads zero.
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) regs[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];
endmodule

// File: rtl/mccpu_core.sv
// rtl/mccpu_core.sv - multi-cycle MIPS32-subset core sharing one memory port for fetch and data
module mccpu_core
  import mccpu_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             Clock,
  input  logic             Resetn,
  mccpu_if.master          mem,
  output logic [31:0]      PC,
  output logic [31:0]      Inst,
  output logic [31:0]      Alu_Result,
  output logic [2:0]       State,
  output logic             Halted,
  output logic [CNT_W-1:0] Retired
);
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, alu_q, mdr_q, a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q, retire, mem_req, xfer;
  logic [31:0]      rd1, rd2;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];

  logic    illegal, is_r, use_imm, zext, is_beq, is_bne, is_j, is_lw, is_sw;
  alu_op_t alu_op;

  always_comb begin
    illegal = 1'b0;
    is_r    = 1'b0;
    use_imm = 1'b0;
    zext    = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: use_imm = 1'b1;
      OP_ANDI: begin use_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin use_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR;  end
      OP_LUI:  begin use_imm = 1'b1; alu_op = ALU_LUI; end
      OP_LW:   begin use_imm = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; is_sw = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:  begin is_bne = 1'b1; alu_op = ALU_SUB; end
      OP_J:    is_j = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  logic [31:0] simm, op_b, alu_out, pc_plus4, br_target;
  logic        br_taken;
  assign simm      = {{16{imm16[15]}}, imm16};
  assign op_b      = use_imm ? (zext ? {16'h0, imm16} : simm) : b_q;
  assign alu_out   = alu_calc(alu_op, a_q, op_b, shamt);
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {simm[29:0], 2'b00};
  assign br_taken  = (is_beq && (a_q == b_q)) || (is_bne && (a_q != b_q));

  // The port stays quiet for the first cycle after reset even though the FSM sits in FETCH.
  assign mem_req = active_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign xfer    = mem_req && mem.Mem_Ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:  if (xfer) state_d = ST_DECODE;
      ST_DECODE: state_d = illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (is_beq || is_bne) begin
          pc_d    = br_taken ? br_target : pc_plus4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (is_j) begin
          pc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = (alu_out[1:0] != 2'b00) ? ST_HALT : ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (xfer) begin
          if (is_sw) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = pc_plus4;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      alu_q    <= 32'h0;
      mdr_q    <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      active_q <= 1'b1;
      if ((state_q == ST_FETCH) && xfer) ir_q <= mem.Mem_Rdata;
      if (state_q == ST_DECODE) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state_q == ST_EXEC) alu_q <= alu_out;
      if ((state_q == ST_MEM) && xfer && !is_sw) mdr_q <= mem.Mem_Rdata;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  mccpu_regfile u_rf (
    .clk    (Clock),
    .we     (state_q == ST_WB),
    .waddr  (is_r ? rd : rt),
    .wdata  (is_lw ? mdr_q : alu_q),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  assign mem.Mem_Req   = mem_req;
  assign mem.Mem_Wen   = (state_q == ST_MEM) && is_sw;
  assign mem.Mem_Addr  = (state_q == ST_MEM) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
  assign mem.Mem_Wdata = b_q;

  assign PC         = pc_q;
  assign Inst       = ir_q;
  assign Alu_Result = alu_q;
  assign State      = state_q;
  assign Halted     = (state_q == ST_HALT);
  assign Retired    = cnt_q;
endmodule

// File: tb/tb_mccpu_core.sv
// tb/tb_mccpu_core.sv - directed bench for mccpu_core with a wait-state memory model
module tb_mccpu_core;
  import mccpu_pkg::*;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  mccpu_if #(.ADDR_W(32)) mif ();

  logic [31:0] PC, Inst, Alu_Result, Retired;
  logic [2:0]  State;
  logic        Halted;

  mccpu_core #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .mem        (mif),
    .PC         (PC),
    .Inst       (Inst),
    .Alu_Result (Alu_Result),
    .State      (State),
    .Halted     (Halted),
    .Retired    (Retired)
  );

  logic [31:0] mem [0:63];
  int delay = 0;
  int wcnt = 0;
  int bad_req = 0;
  int errors = 0;
  int checks = 0;

  // Ready rises after `delay` wait states of a continuously held request.
  assign mif.Mem_Ready = mif.Mem_Req && (wcnt >= delay);
  assign mif.Mem_Rdata = mem[mif.Mem_Addr[7:2]];

  always @(posedge Clock) begin
    if (mif.Mem_Req && !mif.Mem_Ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mif.Mem_Req && (mif.Mem_Addr[1:0] != 2'b00)) bad_req <= bad_req + 1;
  end

  always @(posedge Clock) begin
    if (mif.Mem_Req && mif.Mem_Ready && mif.Mem_Wen) mem[mif.Mem_Addr[7:2]] = mif.Mem_Wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ret(input int n, input string tag);
    int k = 0;
    while (Retired != n && k < 400) begin
      @(negedge Clock);
      k++;
    end
    chk(tag, Retired, n);
  endtask

  task automatic wait_st(input state_t s, input string tag);
    int k = 0;
    while (State != s && k < 400) begin
      @(negedge Clock);
      k++;
    end
    chk(tag, {29'h0, State}, {29'h0, s});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  logic [31:0] alu_exp [0:9];
  int cyc, n;
  logic held, req_seen;

  initial begin
    // Phase 1: ALU latency, waited sw/lw, illegal opcode halt
    clear_mem();
    mem[0] = 32'h2001_0005;  // addi r1,r0,5
    mem[1] = 32'h2002_0007;  // addi r2,r0,7
    mem[2] = 32'h0022_1820;  // add  r3,r1,r2
    mem[3] = 32'hAC03_0008;  // sw   r3,8(r0)
    mem[4] = 32'h8C04_0008;  // lw   r4,8(r0)
    mem[5] = 32'hAC04_0040;  // sw   r4,0x40(r0)
    mem[6] = 32'hFC00_0000;  // illegal opcode 0x3F
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_pc", PC, 32'h0);
    chk("rst_inst", Inst, 32'h0);
    chk("rst_alu", Alu_Result, 32'h0);
    chk("rst_state", {29'h0, State}, {29'h0, ST_FETCH});
    chk("rst_req", {31'h0, mif.Mem_Req}, 32'h0);
    chk("rst_wen", {31'h0, mif.Mem_Wen}, 32'h0);
    chk("rst_halted", {31'h0, Halted}, 32'h0);
    chk("rst_retired", Retired, 32'h0);
    Resetn = 1'b1;
    cyc = 0;
    while (!mif.Mem_Req && cyc < 10) begin
      @(negedge Clock);
      cyc++;
    end
    cyc = 0;
    while (Retired != 3 && cyc < 100) begin
      @(negedge Clock);
      cyc++;
    end
    chk("alu3_cycles", cyc, 12);
    chk("add_result", Alu_Result, 32'd12);

    delay = 3;
    wait_st(ST_MEM, "sw_reach_mem");
    held = 1'b1;
    n = 0;
    while (State == ST_MEM && n < 50) begin
      if (!(mif.Mem_Req && mif.Mem_Wen && mif.Mem_Addr == 32'h8 && mif.Mem_Wdata == 32'd12))
        held = 1'b0;
      n++;
      @(negedge Clock);
    end
    chk("sw_hold", {31'h0, held}, 32'h1);
    chk("sw_mem_cycles", n, 4);
    wait_ret(4, "sw_retire");
    chk("sw_data", mem[2], 32'd12);
    wait_st(ST_MEM, "lw_reach_mem");
    chk("lw_wen", {31'h0, mif.Mem_Wen}, 32'h0);
    chk("lw_addr", mif.Mem_Addr, 32'h8);
    wait_ret(6, "lw_sw_retire");
    chk("lw_value", mem[16], 32'd12);
    wait_st(ST_HALT, "illegal_halt_state");
    chk("illegal_halted", {31'h0, Halted}, 32'h1);
    chk("illegal_pc", PC, 32'h18);
    req_seen = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      if (mif.Mem_Req) req_seen = 1'b1;
    end
    chk("halt_no_req", {31'h0, req_seen}, 32'h0);
    chk("halt_retired_frozen", Retired, 32'd6);

    // Phase 2: beq taken, j, misaligned lw halt (registers survive reset)
    Resetn = 1'b0;
    clear_mem();
    mem[4]  = 32'h1021_0002;  // beq r1,r1,+2
    mem[5]  = 32'hFC00_0000;
    mem[6]  = 32'hFC00_0000;
    mem[7]  = 32'h0800_000C;  // j 0x30
    mem[12] = 32'h8C05_0006;  // lw r5,6(r0)
    delay = 1;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    wait_ret(5, "beq_retire");
    chk("beq_pc", PC, 32'h1C);
    chk("beq_fetch_addr", mif.Mem_Addr, 32'h1C);
    wait_ret(6, "j_retire");
    chk("j_pc", PC, 32'h30);
    wait_st(ST_HALT, "misalign_halt");
    chk("misalign_no_req", bad_req, 0);
    chk("misalign_retired", Retired, 32'd6);

    // Phase 3: bne on equal registers falls through
    Resetn = 1'b0;
    clear_mem();
    mem[4] = 32'h1421_0002;  // bne r1,r1,+2
    mem[5] = 32'hFC00_0000;
    mem[7] = 32'hFC00_0000;
    delay = 0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    wait_ret(5, "bne_retire");
    chk("bne_pc", PC, 32'h14);
    chk("bne_fetch_addr", mif.Mem_Addr, 32'h14);
    wait_st(ST_HALT, "bne_halt");
    chk("bne_retired", Retired, 32'd5);

    // Phase 4: remaining ALU operations
    Resetn = 1'b0;
    clear_mem();
    mem[0]  = 32'h0022_3022; alu_exp[0] = 32'hFFFF_FFFE;  // sub  r6,r1,r2
    mem[1]  = 32'h00C1_382A; alu_exp[1] = 32'h0000_0001;  // slt  r7,r6,r1
    mem[2]  = 32'h0022_4024; alu_exp[2] = 32'h0000_0005;  // and  r8,r1,r2
    mem[3]  = 32'h0022_4825; alu_exp[3] = 32'h0000_0007;  // or   r9,r1,r2
    mem[4]  = 32'h0002_5100; alu_exp[4] = 32'h0000_0070;  // sll  r10,r2,4
    mem[5]  = 32'h0006_5F02; alu_exp[5] = 32'h0000_000F;  // srl  r11,r6,28
    mem[6]  = 32'h3C0C_ABCD; alu_exp[6] = 32'hABCD_0000;  // lui  r12,0xABCD
    mem[7]  = 32'h358D_8001; alu_exp[7] = 32'hABCD_8001;  // ori  r13,r12,0x8001
    mem[8]  = 32'h30CE_8001; alu_exp[8] = 32'h0000_8000;  // andi r14,r6,0x8001
    mem[9]  = 32'h20CF_FFFD; alu_exp[9] = 32'hFFFF_FFFB;  // addi r15,r6,-3
    mem[10] = 32'hFC00_0000;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_ret(i + 1, "alu_retire");
      chk($sformatf("alu_op%0d", i), Alu_Result, alu_exp[i]);
    end
    wait_st(ST_HALT, "alu_halt");

    // Phase 5: reset asserted while a fetch is waiting on Ready
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    wait_ret(2, "midrst_pre");
    delay = 5;
    wait_st(ST_FETCH, "midrst_fetch");
    @(negedge Clock);
    chk("midrst_waiting", {31'h0, mif.Mem_Req}, 32'h1);
    Resetn = 1'b0;
    @(negedge Clock);
    chk("midrst_req", {31'h0, mif.Mem_Req}, 32'h0);
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_state", {29'h0, State}, {29'h0, ST_FETCH});
    chk("midrst_retired", Retired, 32'h0);
    Resetn = 1'b1;
    delay = 0;
    @(negedge Clock);
    chk("postrst_req", {31'h0, mif.Mem_Req}, 32'h1);
    chk("postrst_addr", mif.Mem_Addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
